// File: rtl/truth_table_sequencer.sv
// Clocked sweep controller: walks a shared input vector through every minterm and
// compares the responses of two implementations. Define TT_SEQ_HALT_ON_ERR_EN to stop at the first mismatch.
module truth_table_sequencer #(
  parameter int N_IN   = 2,
  parameter int SETTLE = 1,
  parameter int CNT_W  = N_IN + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [N_IN-1:0]  in_vec,
  input  logic             resp_a,
  input  logic             resp_b,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_cnt,
  output logic             err_valid,
  output logic [N_IN-1:0]  first_err
);

  localparam int SC_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [SC_W-1:0]  SETTLE_INIT = SC_W'(SETTLE - 1);
  localparam logic [SC_W-1:0]  SC_ONE      = SC_W'(1);
  localparam logic [N_IN-1:0]  VEC_ONE     = N_IN'(1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETTLE = 2'd1;
  localparam logic [1:0] S_SAMPLE = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [N_IN-1:0]  vec_q, vec_d;
  logic [SC_W-1:0]  settle_q, settle_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic             err_valid_q, err_valid_d;
  logic [N_IN-1:0]  first_err_q, first_err_d;
  logic             pass_q, pass_d;
  logic             mismatch;
  logic             go_done;

  assign mismatch = resp_a ^ resp_b;

  // The last minterm always ends the sweep; with the halt option the first mismatch does too.
`ifdef TT_SEQ_HALT_ON_ERR_EN
  assign go_done = (vec_q == '1) || mismatch;
`else
  assign go_done = (vec_q == '1);
`endif

  always_comb begin
    state_d     = state_q;
    vec_d       = vec_q;
    settle_d    = settle_q;
    err_cnt_d   = err_cnt_q;
    err_valid_d = err_valid_q;
    first_err_d = first_err_q;
    pass_d      = pass_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d     = S_SETTLE;
          vec_d       = '0;
          settle_d    = SETTLE_INIT;
          err_cnt_d   = '0;
          err_valid_d = 1'b0;
          first_err_d = '0;
          pass_d      = 1'b0;
        end
      end
      S_SETTLE: begin
        if (settle_q == '0) begin
          state_d = S_SAMPLE;
        end else begin
          settle_d = settle_q - SC_ONE;
        end
      end
      S_SAMPLE: begin
        if (mismatch) begin
          if (err_cnt_q != '1) begin
            err_cnt_d = err_cnt_q + CNT_ONE;
          end
          if (!err_valid_q) begin
            err_valid_d = 1'b1;
            first_err_d = vec_q;
          end
        end
        // pass is resolved on entry to DONE so it is already valid alongside the done pulse.
        if (go_done) begin
          state_d = S_DONE;
          vec_d   = '0;
          pass_d  = (err_cnt_d == '0);
        end else begin
          state_d  = S_SETTLE;
          vec_d    = vec_q + VEC_ONE;
          settle_d = SETTLE_INIT;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      vec_q       <= '0;
      settle_q    <= '0;
      err_cnt_q   <= '0;
      err_valid_q <= 1'b0;
      first_err_q <= '0;
      pass_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      vec_q       <= vec_d;
      settle_q    <= settle_d;
      err_cnt_q   <= err_cnt_d;
      err_valid_q <= err_valid_d;
      first_err_q <= first_err_d;
      pass_q      <= pass_d;
    end
  end

  assign in_vec    = vec_q;
  assign busy      = (state_q == S_SETTLE) || (state_q == S_SAMPLE);
  assign done      = (state_q == S_DONE);
  assign pass      = pass_q;
  assign err_cnt   = err_cnt_q;
  assign err_valid = err_valid_q;
  assign first_err = first_err_q;

endmodule

// File: tb/tb_truth_table_sequencer.sv
// Scoreboard bench for truth_table_sequencer: expected sweep results are queued at start
// and a negedge monitor pops and compares them whenever done pulses.
module tb_truth_table_sequencer;

  localparam int N_IN   = 2;
  localparam int SETTLE = 1;
  localparam int CNT_W  = N_IN + 1;
  localparam int NMIN   = 1 << N_IN;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [N_IN-1:0]  in_vec;
  logic             resp_a, resp_b;
  logic             busy, done, pass, err_valid;
  logic [CNT_W-1:0] err_cnt;
  logic [N_IN-1:0]  first_err;
  logic [NMIN-1:0]  maskA = '0;
  logic [NMIN-1:0]  maskB = '0;

  int checks = 0;
  int failures = 0;
  int cycleCnt = 0;

  typedef struct {
    int errCnt;
    int firstErr;
    bit errValid;
    bit pass;
    int doneCycle;
  } exp_t;

  exp_t sb[$];

  // Truth tables indexed by {x,y}: sameFn = ~x&y, invFn = ~(y&~x), zeroFn = 0.
  localparam logic [NMIN-1:0] SAME_FN = 4'b0010;
  localparam logic [NMIN-1:0] INV_FN  = 4'b1101;
  localparam logic [NMIN-1:0] ZERO_FN = 4'b0000;

  assign resp_a = maskA[in_vec];
  assign resp_b = maskB[in_vec];

  truth_table_sequencer #(.N_IN(N_IN), .SETTLE(SETTLE), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_vec(in_vec),
    .resp_a(resp_a), .resp_b(resp_b), .busy(busy), .done(done), .pass(pass),
    .err_cnt(err_cnt), .err_valid(err_valid), .first_err(first_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at cycle %0d", name, act, exp, cycleCnt);
    end
  endtask

  // Reference: walk the minterms in order, tallying differing truth-table entries.
  function automatic exp_t modelSweep(input logic [NMIN-1:0] a, input logic [NMIN-1:0] b,
                                      input int acceptEdge);
    exp_t e;
    int sampled;
    sampled    = 0;
    e.errCnt   = 0;
    e.firstErr = 0;
    e.errValid = 1'b0;
    for (int m = 0; m < NMIN; m++) begin
      sampled++;
      if (a[m] != b[m]) begin
        if (!e.errValid) begin
          e.errValid = 1'b1;
          e.firstErr = m;
        end
        e.errCnt++;
`ifdef TT_SEQ_HALT_ON_ERR_EN
        break;
`endif
      end
    end
    if (e.errCnt > (1 << CNT_W) - 1) e.errCnt = (1 << CNT_W) - 1;
    e.pass      = (e.errCnt == 0);
    e.doneCycle = acceptEdge + sampled * (SETTLE + 1);
    return e;
  endfunction

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n === 1'b1 && done === 1'b1) begin
      if (sb.size() == 0) begin
        checkOutput("unexpectedDone", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        checkOutput("doneCycle", cycleCnt, e.doneCycle);
        checkOutput("errCnt", 32'(err_cnt), e.errCnt);
        checkOutput("errValid", 32'(err_valid), 32'(e.errValid));
        checkOutput("pass", 32'(pass), 32'(e.pass));
        if (e.errValid) checkOutput("firstErr", 32'(first_err), e.firstErr);
        checkOutput("busyAtDone", 32'(busy), 32'd0);
        checkOutput("inVecAtDone", 32'(in_vec), 32'd0);
      end
    end
  end

  task automatic checkReset();
    checkOutput("resetBusy", 32'(busy), 32'd0);
    checkOutput("resetDone", 32'(done), 32'd0);
    checkOutput("resetPass", 32'(pass), 32'd0);
    checkOutput("resetErrCnt", 32'(err_cnt), 32'd0);
    checkOutput("resetErrValid", 32'(err_valid), 32'd0);
    checkOutput("resetFirstErr", 32'(first_err), 32'd0);
    checkOutput("resetInVec", 32'(in_vec), 32'd0);
  endtask

  task automatic checkHeld(input exp_t e);
    checkOutput("heldPass", 32'(pass), 32'(e.pass));
    checkOutput("heldErrCnt", 32'(err_cnt), e.errCnt);
    checkOutput("heldErrValid", 32'(err_valid), 32'(e.errValid));
    if (e.errValid) checkOutput("heldFirstErr", 32'(first_err), e.firstErr);
    checkOutput("heldIdleBusy", 32'(busy), 32'd0);
  endtask

  task automatic waitDrain(input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checkOutput("doneTimeout", 32'd0, 32'd1);
      sb.delete();
    end
  endtask

  // One start pulse from IDLE; the scoreboard entry is queued before the accepting edge.
  task automatic applyStimulus(input logic [NMIN-1:0] a, input logic [NMIN-1:0] b);
    exp_t e;
    @(posedge clk); #1;
    maskA = a;
    maskB = b;
    start = 1'b1;
    e = modelSweep(a, b, cycleCnt + 1);
    sb.push_back(e);
    @(posedge clk); #1;
    start = 1'b0;
    waitDrain(40);
    repeat (2) @(posedge clk);
    #1;
    checkHeld(e);
  endtask

  initial begin : stimulus
    exp_t e;
    int c;
    $display("[TB] starting truth_table_sequencer bench");
    repeat (3) @(posedge clk);
    #1;
    checkReset();
    rst_n = 1'b1;

    applyStimulus(SAME_FN, SAME_FN);
    applyStimulus(SAME_FN, INV_FN);
    applyStimulus(SAME_FN, ZERO_FN);

    // Reset while minterm 2 is settling: outputs clear and no done follows.
    @(posedge clk); #1;
    maskA = SAME_FN;
    maskB = INV_FN;
    start = 1'b1;
    c = cycleCnt + 1;
    sb.push_back(modelSweep(SAME_FN, INV_FN, c));
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    checkOutput("midSweepBusy", 32'(busy), 32'd1);
    checkOutput("midSweepInVec", 32'(in_vec), 32'd2);
    rst_n = 1'b0;
    sb.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    checkReset();
    repeat (12) @(posedge clk);
    applyStimulus(SAME_FN, INV_FN);

    // Start pulses while busy and while in DONE must be dropped.
    @(posedge clk); #1;
    maskA = SAME_FN;
    maskB = ZERO_FN;
    start = 1'b1;
    c = cycleCnt + 1;
    sb.push_back(modelSweep(SAME_FN, ZERO_FN, c));
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      start = (k == 1 || k == 7 || k == 8);
    end
    waitDrain(5);
    repeat (10) @(posedge clk);
    #1;
    checkOutput("ignoredStartBusy", 32'(busy), 32'd0);

    // Start held high: three back-to-back sweeps spaced ten cycles apart.
    @(posedge clk); #1;
    maskA = 4'($urandom);
    maskB = 4'($urandom);
    start = 1'b1;
    c = cycleCnt + 1;
    for (int s = 0; s < 3; s++) begin
      e = modelSweep(maskA, maskB, c + s * (NMIN * (SETTLE + 1) + 2));
      sb.push_back(e);
    end
    repeat (21) @(posedge clk);
    #1;
    start = 1'b0;
    waitDrain(40);
    repeat (2) @(posedge clk);
    #1;
    checkHeld(e);

    for (int i = 0; i < 20; i++) begin
      applyStimulus(4'($urandom), 4'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #100000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] simulation did not finish");
  end

endmodule
